ultrasonic_ctrl_mc: RTL and testbench
=====================================

// Module: ultrasonic_ctrl_mc
// PURPOSE
//  Multi-channel successor of the ultrasonic control unit: accepts per-channel amplitude/power
//  commands over a valid/ready port, ramps each channel's DAC code toward its target, and keeps
//  a circular command log readable by address. Sits between the command decoder and the DAC bank.
// PARAMETERS
//  NCH        4    number of DAC channels (>=1); CH_W = max(1,$clog2(NCH))
//  DAC_W      12   DAC code width per channel
//  AMT_W      8    cmd_amount width (AMT_W <= DAC_W)
//  INC_STEP   16   target change applied by INC/DEC, in DAC codes
//  RAMP_STEP  64   max |current-target| change per ramp tick
//  RAMP_DIV   4    clocks per ramp tick (>=1; 1 = every clock)
//  LOG_DEPTH  64   log entries (power of 2); LA_W = $clog2(LOG_DEPTH)
//  LOG_WRAP   1    1: overwrite oldest when full; 0: stall commands (cmd_ready=0) when full
// PORTS
//  clk          in   1             clock, all state on rising edge
//  rst_n        in   1             asynchronous active-low reset
//  cmd_valid    in   1             command present
//  cmd_ready    out  1             command accepted when cmd_valid & cmd_ready
//  cmd_ch       in   CH_W          target channel
//  cmd_op       in   3             0 NOP,1 SET,2 INC,3 DEC,4 ON,5 OFF; 6,7 illegal
//  cmd_amount   in   AMT_W         SET amount
//  dac_out      out  NCH*DAC_W     channel i at [i*DAC_W +: DAC_W], registered
//  ch_on        out  NCH           channel enabled
//  ramp_busy    out  NCH           channel on and current != target
//  err_pulse    out  1             1-cycle pulse on accepted illegal command
//  log_clear    in   1             empty the log
//  log_rd_en    in   1             read strobe
//  log_rd_addr  in   LA_W          0 = oldest entry
//  log_rd_data  out  4+CH_W+AMT_W  {err,op[2:0],ch,amount}, 1-cycle read latency
//  log_count    out  LA_W+1        valid entries, saturates at LOG_DEPTH
//  log_full     out  1             log_count == LOG_DEPTH
// BEHAVIOUR
//  Reset: dac_out, ch_on, ramp_busy, err_pulse, log_rd_data, log_count, log_full, all targets,
//   current levels, prescaler, log pointers = 0; cmd_ready = 1.
//  cmd_ready = ~(LOG_WRAP==0 & log_full & ~log_clear). Accepted at edge N -> effects at N+1.
//  SET: target = cmd_amount << (DAC_W-AMT_W). INC/DEC: target +/- INC_STEP, saturating at
//   2^DAC_W-1 / 0. ON: ch_on=1, current unchanged (0 after OFF). OFF: ch_on=0, current=0
//   same edge; target kept. SET/INC/DEC on an off channel update target only.
//  Illegal (op>5 or cmd_ch>=NCH): no channel state change, err_pulse high at N+1, logged with err=1.
//  NOP: accepted, not logged, no effect.
//  Ramp: prescaler counts 0..RAMP_DIV-1; tick at wrap. On tick each on-channel moves current
//   toward target by min(RAMP_STEP,|diff|); never overshoots. dac_out_i = ch_on_i ? current_i : 0.
//  Log: non-NOP accepted commands written at wr_ptr, wr_ptr++ mod LOG_DEPTH, count++ saturating.
//   Full & LOG_WRAP=1: oldest overwritten, rd base advances. log_clear: ptrs/count=0; if a
//   command is accepted the same cycle it becomes entry 0 (count=1).
//  Read: log_rd_en at N -> log_rd_data at N+1 = entry (base+addr) mod DEPTH; addr>=count -> 0;
//   holds value when log_rd_en=0. Same-cycle write+read of same slot returns old contents.
//  Async reset mid-ramp returns all outputs to reset values immediately.
// TESTING
//  1 Reset, ON ch0, SET ch0 amt=0xFF (RAMP_DIV=1): ch0 dac 0,64,128..4032,4080 then holds; busy drops at 4080.
//  2 SET ch1 0x00, DEC x3 -> target 0; SET 0xFF, INC -> target 4095 (saturate).
//  3 Ramp ch2 halfway, OFF -> dac 0 next cycle; ON -> ramps from 0 to kept target.
//  4 cmd_op=6 or cmd_ch=NCH -> err_pulse 1 cycle, no state change, log entry err=1.
//  5 LOG_DEPTH+3 commands: WRAP=1 count=64, addr0 = 4th cmd; WRAP=0 cmd_ready=0 after 64 until log_clear.
//  6 log_clear + SET same cycle -> count=1, addr0 = SET; read addr 5 -> 0; rst_n low mid-ramp -> all 0.

Source files
------------

// File: rtl/ultrasonic_ctrl_mc.sv
// Multi-channel ultrasonic DAC controller: per-channel target/ramp plus a circular command log.
// Latency: a command accepted at edge N takes effect at N+1; log reads return one clock after log_rd_en.
// Backpressure: cmd_ready is low only when LOG_WRAP=0 and the log is full (a same-cycle log_clear lifts it).
module ultrasonic_ctrl_mc #(
  parameter int NCH       = 4,
  parameter int DAC_W     = 12,
  parameter int AMT_W     = 8,
  parameter int INC_STEP  = 16,
  parameter int RAMP_STEP = 64,
  parameter int RAMP_DIV  = 4,
  parameter int LOG_DEPTH = 64,
  parameter int LOG_WRAP  = 1,
  localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int LA_W     = $clog2(LOG_DEPTH),
  localparam int LOG_DW   = 4 + CH_W + AMT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [CH_W-1:0]        cmd_ch,
  input  logic [2:0]             cmd_op,
  input  logic [AMT_W-1:0]       cmd_amount,
  output logic [NCH*DAC_W-1:0]   dac_out,
  output logic [NCH-1:0]         ch_on,
  output logic [NCH-1:0]         ramp_busy,
  output logic                   err_pulse,
  input  logic                   log_clear,
  input  logic                   log_rd_en,
  input  logic [LA_W-1:0]        log_rd_addr,
  output logic [LOG_DW-1:0]      log_rd_data,
  output logic [LA_W:0]          log_count,
  output logic                   log_full
);

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_SET = 3'd1,
    OP_INC = 3'd2,
    OP_DEC = 3'd3,
    OP_ON  = 3'd4,
    OP_OFF = 3'd5
  } op_e;

  localparam int PS_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DAC_W:0] RSTEP = (DAC_W+1)'(RAMP_STEP);
  localparam logic [DAC_W:0] ISTEP = (DAC_W+1)'(INC_STEP);
  localparam logic [DAC_W:0] DMAX  = {1'b0, {DAC_W{1'b1}}};
  localparam logic [LA_W:0]  DEPTH = (LA_W+1)'(LOG_DEPTH);

  // channel state
  logic [DAC_W-1:0] tgt_q [NCH];
  logic [DAC_W-1:0] cur_q [NCH];
  logic [DAC_W-1:0] tgt_d [NCH];
  logic [DAC_W-1:0] cur_d [NCH];
  logic [NCH-1:0]   on_q, on_d, busy_d;
  logic [NCH*DAC_W-1:0] dac_d;

  logic [PS_W-1:0] presc_q;
  logic            tick;

  logic            cmd_fire, illegal, apply, log_we;
  logic [DAC_W-1:0] set_val;

  // log state
  logic [LOG_DW-1:0] log_mem [LOG_DEPTH];
  logic [LA_W-1:0]   wr_ptr, wr_idx, rd_base, rd_idx;
  logic [LOG_DW-1:0] log_entry;

  // Moves cur toward tgt by at most RAMP_STEP, landing exactly on tgt when close.
  function automatic logic [DAC_W-1:0] ramp_next(input logic [DAC_W-1:0] cur,
                                                 input logic [DAC_W-1:0] tgt);
    logic [DAC_W:0] diff;
    diff = '0;
    ramp_next = cur;
    if (cur < tgt) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      ramp_next = (diff > RSTEP) ? DAC_W'({1'b0, cur} + RSTEP) : tgt;
    end else if (cur > tgt) begin
      diff = {1'b0, cur} - {1'b0, tgt};
      ramp_next = (diff > RSTEP) ? DAC_W'({1'b0, cur} - RSTEP) : tgt;
    end
  endfunction

  function automatic logic [DAC_W-1:0] inc_sat(input logic [DAC_W-1:0] t);
    logic [DAC_W:0] sum;
    sum = {1'b0, t} + ISTEP;
    inc_sat = (sum > DMAX) ? {DAC_W{1'b1}} : sum[DAC_W-1:0];
  endfunction

  function automatic logic [DAC_W-1:0] dec_sat(input logic [DAC_W-1:0] t);
    logic [DAC_W:0] dif;
    dif = {1'b0, t} - ISTEP;
    dec_sat = ({1'b0, t} < ISTEP) ? '0 : dif[DAC_W-1:0];
  endfunction

  assign cmd_ready = ~((LOG_WRAP == 0) & log_full & ~log_clear);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign illegal   = (cmd_op > 3'd5) | ({1'b0, cmd_ch} >= (CH_W+1)'(NCH));
  assign apply     = cmd_fire & ~illegal;
  // Illegal commands are logged even when their op field is NOP.
  assign log_we    = cmd_fire & (illegal | (cmd_op != OP_NOP));
  assign set_val   = DAC_W'(cmd_amount) << (DAC_W - AMT_W);
  assign tick      = (presc_q == PS_W'(RAMP_DIV - 1));
  assign ch_on     = on_q;

  // Next channel state: ramp first, then the command overrides (OFF forces current to 0).
  always_comb begin
    on_d   = on_q;
    busy_d = '0;
    dac_d  = '0;
    for (int i = 0; i < NCH; i++) begin
      tgt_d[i] = tgt_q[i];
      cur_d[i] = cur_q[i];
      if (tick && on_q[i]) cur_d[i] = ramp_next(cur_q[i], tgt_q[i]);
      if (apply && (cmd_ch == CH_W'(i))) begin
        case (cmd_op)
          OP_SET:  tgt_d[i] = set_val;
          OP_INC:  tgt_d[i] = inc_sat(tgt_q[i]);
          OP_DEC:  tgt_d[i] = dec_sat(tgt_q[i]);
          OP_ON:   on_d[i]  = 1'b1;
          OP_OFF: begin
            on_d[i]  = 1'b0;
            cur_d[i] = '0;
          end
          default: ;
        endcase
      end
      busy_d[i] = on_d[i] & (cur_d[i] != tgt_d[i]);
      dac_d[i*DAC_W +: DAC_W] = on_d[i] ? cur_d[i] : '0;
    end
  end

  // Channel registers; outputs are registered copies of the next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        tgt_q[i] <= '0;
        cur_q[i] <= '0;
      end
      on_q      <= '0;
      ramp_busy <= '0;
      dac_out   <= '0;
      err_pulse <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        tgt_q[i] <= tgt_d[i];
        cur_q[i] <= cur_d[i];
      end
      on_q      <= on_d;
      ramp_busy <= busy_d;
      dac_out   <= dac_d;
      err_pulse <= cmd_fire & illegal;
    end
  end

  // Ramp prescaler: counts 0..RAMP_DIV-1, tick asserted on the wrap count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    presc_q <= '0;
    else if (tick) presc_q <= '0;
    else           presc_q <= presc_q + 1'b1;
  end

  // Oldest entry sits count slots behind the write pointer (count=DEPTH wraps to wr_ptr itself).
  assign rd_base   = wr_ptr - log_count[LA_W-1:0];
  assign rd_idx    = rd_base + log_rd_addr;
  assign wr_idx    = log_clear ? '0 : wr_ptr;
  assign log_entry = {illegal, cmd_op, cmd_ch, cmd_amount};
  assign log_full  = (log_count == DEPTH);

  // Log pointers; a clear with a simultaneous write leaves that write as entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      log_count <= '0;
    end else if (log_clear) begin
      wr_ptr    <= log_we ? LA_W'(1) : '0;
      log_count <= log_we ? (LA_W+1)'(1) : '0;
    end else if (log_we) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (!log_full) log_count <= log_count + 1'b1;
    end
  end

  // Log storage (no reset needed: reads beyond count return zero).
  always_ff @(posedge clk) begin
    if (log_we) log_mem[wr_idx] <= log_entry;
  end

  // Registered log read; holds its value when no read is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      log_rd_data <= '0;
    end else if (log_rd_en) begin
      log_rd_data <= ({1'b0, log_rd_addr} < log_count) ? log_mem[rd_idx] : '0;
    end
  end

endmodule

// File: tb/tb_ultrasonic_ctrl_mc.sv
// Directed self-checking bench for ultrasonic_ctrl_mc.
// dut1: RAMP_DIV=1, LOG_WRAP=1; dut2: RAMP_DIV=4, LOG_WRAP=0. Both use NCH=3 so cmd_ch=NCH is encodable.
// Inputs driven 1 time unit after the rising edge; outputs checked at that same point.
module tb_ultrasonic_ctrl_mc;
  localparam int NCH = 3, DAC_W = 12, AMT_W = 8, CH_W = 2, LA_W = 6, LDW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic c1_valid, c1_ready, err1, clr1, rden1, full1;
  logic [CH_W-1:0] c1_ch;
  logic [2:0] c1_op;
  logic [AMT_W-1:0] c1_amt;
  logic [NCH*DAC_W-1:0] dac1;
  logic [NCH-1:0] on1, busy1;
  logic [LA_W-1:0] rdaddr1;
  logic [LDW-1:0] rddata1;
  logic [LA_W:0] cnt1;

  logic c2_valid, c2_ready, err2, clr2, rden2, full2;
  logic [CH_W-1:0] c2_ch;
  logic [2:0] c2_op;
  logic [AMT_W-1:0] c2_amt;
  logic [NCH*DAC_W-1:0] dac2;
  logic [NCH-1:0] on2, busy2;
  logic [LA_W-1:0] rdaddr2;
  logic [LDW-1:0] rddata2;
  logic [LA_W:0] cnt2;

  int checks = 0;
  int failures = 0;

  ultrasonic_ctrl_mc #(.NCH(NCH), .RAMP_DIV(1), .LOG_WRAP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_ch(c1_ch),
    .cmd_op(c1_op), .cmd_amount(c1_amt), .dac_out(dac1), .ch_on(on1), .ramp_busy(busy1),
    .err_pulse(err1), .log_clear(clr1), .log_rd_en(rden1), .log_rd_addr(rdaddr1),
    .log_rd_data(rddata1), .log_count(cnt1), .log_full(full1));

  ultrasonic_ctrl_mc #(.NCH(NCH), .RAMP_DIV(4), .LOG_WRAP(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(c2_valid), .cmd_ready(c2_ready), .cmd_ch(c2_ch),
    .cmd_op(c2_op), .cmd_amount(c2_amt), .dac_out(dac2), .ch_on(on2), .ramp_busy(busy2),
    .err_pulse(err2), .log_clear(clr2), .log_rd_en(rden2), .log_rd_addr(rdaddr2),
    .log_rd_data(rddata2), .log_count(cnt2), .log_full(full2));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DAC_W-1:0] d1(input int i);
    return dac1[i*DAC_W +: DAC_W];
  endfunction

  function automatic logic [DAC_W-1:0] d2(input int i);
    return dac2[i*DAC_W +: DAC_W];
  endfunction

  function automatic logic [LDW-1:0] ent(input logic e, input logic [2:0] op,
                                         input logic [1:0] ch, input logic [7:0] amt);
    return {e, op, ch, amt};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [1:0] ch, input logic [2:0] op, input logic [7:0] amt);
    c1_valid = 1'b1; c1_ch = ch; c1_op = op; c1_amt = amt;
    step(1);
    c1_valid = 1'b0;
  endtask

  task automatic send2(input logic [1:0] ch, input logic [2:0] op, input logic [7:0] amt);
    c2_valid = 1'b1; c2_ch = ch; c2_op = op; c2_amt = amt;
    step(1);
    c2_valid = 1'b0;
  endtask

  task automatic read1(input logic [5:0] a);
    rden1 = 1'b1; rdaddr1 = a;
    step(1);
    rden1 = 1'b0;
  endtask

  task automatic read2(input logic [5:0] a);
    rden2 = 1'b1; rdaddr2 = a;
    step(1);
    rden2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    rst_n = 1'b0;
    c1_valid = 0; c1_ch = 0; c1_op = 0; c1_amt = 0; clr1 = 0; rden1 = 0; rdaddr1 = 0;
    c2_valid = 0; c2_ch = 0; c2_op = 0; c2_amt = 0; clr2 = 0; rden2 = 0; rdaddr2 = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // reset state
    chk("rst_dac", dac1, 0);
    chk("rst_on", on1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_err", err1, 0);
    chk("rst_ready", c1_ready, 1);
    chk("rst_cnt", cnt1, 0);
    chk("rst_full", full1, 0);
    chk("rst_rd", rddata1, 0);

    // dut2 prescaler: tick on every 4th clock from reset
    send2(0, 3'd4, 0);
    send2(0, 3'd1, 8'hFF);
    chk("div_a", d2(0), 0);
    step(2); chk("div_b", d2(0), 64);
    step(3); chk("div_c", d2(0), 64);
    step(1); chk("div_d", d2(0), 128);

    // dut2 log without wrap: stall when full, clear lifts ready the same cycle
    clr2 = 1'b1; step(1); clr2 = 1'b0;
    chk("nw_clr", cnt2, 0);
    c2_valid = 1'b1; c2_op = 3'd1; c2_ch = 0;
    for (int k = 0; k < 64; k++) begin
      c2_amt = 8'(k);
      step(1);
    end
    chk("nw_ready", c2_ready, 0);
    chk("nw_full", full2, 1);
    c2_amt = 8'd99;
    step(2);
    chk("nw_stall_cnt", cnt2, 64);
    read2(63); chk("nw_rd63", rddata2, ent(0, 3'd1, 0, 8'd63));
    read2(0);  chk("nw_rd0", rddata2, ent(0, 3'd1, 0, 8'd0));
    clr2 = 1'b1;
    #1;
    chk("nw_clr_ready", c2_ready, 1);
    step(1);
    clr2 = 1'b0; c2_valid = 1'b0;
    chk("nw_cnt1", cnt2, 1);
    read2(0); chk("nw_rd_after", rddata2, ent(0, 3'd1, 0, 8'd99));

    // 1: ch0 ramps to 4080 in steps of 64
    send1(0, 3'd4, 0);
    chk("t1_on", on1, 3'b001);
    send1(0, 3'd1, 8'hFF);
    chk("t1_d0", d1(0), 0);
    chk("t1_busy0", busy1[0], 1);
    for (int k = 1; k <= 64; k++) begin
      step(1);
      e = (k * 64 > 4080) ? 4080 : k * 64;
      chk("t1_ramp", d1(0), e);
      chk("t1_busy", busy1[0], (e != 4080));
    end
    step(3);
    chk("t1_hold", d1(0), 4080);

    // 2: DEC saturates at 0, INC saturates at 4095
    send1(1, 3'd1, 8'h00);
    send1(1, 3'd3, 0); send1(1, 3'd3, 0); send1(1, 3'd3, 0);
    send1(1, 3'd4, 0);
    step(2);
    chk("t2_zero", d1(1), 0);
    chk("t2_idle", busy1[1], 0);
    send1(1, 3'd1, 8'hFF);
    send1(1, 3'd2, 0);
    chk("t2_first", d1(1), 64);
    step(70);
    chk("t2_sat", d1(1), 4095);
    send1(1, 3'd3, 0);
    chk("t2_dec_a", d1(1), 4095);
    step(1);
    chk("t2_dec_b", d1(1), 4079);

    // 3: OFF mid-ramp zeros output, ON resumes from 0 to kept target
    send1(2, 3'd4, 0);
    send1(2, 3'd1, 8'h80);
    step(10);
    chk("t3_mid", d1(2), 640);
    send1(2, 3'd5, 0);
    chk("t3_off", d1(2), 0);
    chk("t3_off_on", on1[2], 0);
    chk("t3_off_busy", busy1[2], 0);
    step(3);
    chk("t3_off_hold", d1(2), 0);
    send1(2, 3'd4, 0);
    chk("t3_on", d1(2), 0);
    step(1);
    chk("t3_r1", d1(2), 64);
    step(31);
    chk("t3_done", d1(2), 2048);
    chk("t3_idle", busy1[2], 0);

    // 4: NOP not logged; illegal op / channel pulse err, change nothing, log err=1
    send1(0, 3'd0, 0);
    chk("t4_nop_err", err1, 0);
    chk("t4_nop_cnt", cnt1, 14);
    send1(0, 3'd6, 8'hAA);
    chk("t4_err_op", err1, 1);
    chk("t4_dac_op", dac1, {12'd2048, 12'd4079, 12'd4080});
    step(1);
    chk("t4_err_low", err1, 0);
    send1(2'd3, 3'd1, 8'h10);
    chk("t4_err_ch", err1, 1);
    chk("t4_dac_ch", dac1, {12'd2048, 12'd4079, 12'd4080});
    chk("t4_on_ch", on1, 3'b111);
    chk("t4_cnt", cnt1, 16);
    read1(14); chk("t4_log_op", rddata1, ent(1, 3'd6, 2'd0, 8'hAA));
    read1(15); chk("t4_log_ch", rddata1, ent(1, 3'd1, 2'd3, 8'h10));
    step(2);   chk("t4_rd_hold", rddata1, ent(1, 3'd1, 2'd3, 8'h10));
    read1(0);  chk("t4_log0", rddata1, ent(0, 3'd4, 2'd0, 8'h00));
    read1(16); chk("t4_beyond", rddata1, 0);

    // 5: 67 commands with wrap: count saturates, oldest three overwritten
    clr1 = 1'b1; step(1); clr1 = 1'b0;
    chk("t5_clr", cnt1, 0);
    c1_valid = 1'b1; c1_op = 3'd1; c1_ch = 0;
    for (int k = 0; k < 67; k++) begin
      c1_amt = 8'(k);
      step(1);
    end
    c1_valid = 1'b0;
    chk("t5_cnt", cnt1, 64);
    chk("t5_full", full1, 1);
    chk("t5_ready", c1_ready, 1);
    read1(0);  chk("t5_rd0", rddata1, ent(0, 3'd1, 0, 8'd3));
    read1(1);  chk("t5_rd1", rddata1, ent(0, 3'd1, 0, 8'd4));
    read1(63); chk("t5_rd63", rddata1, ent(0, 3'd1, 0, 8'd66));

    // 6: clear + SET same cycle, out-of-range read, async reset mid-ramp
    clr1 = 1'b1;
    send1(2, 3'd1, 8'hFF);
    clr1 = 1'b0;
    chk("t6_cnt", cnt1, 1);
    read1(0); chk("t6_rd0", rddata1, ent(0, 3'd1, 2'd2, 8'hFF));
    read1(5); chk("t6_rd5", rddata1, 0);
    chk("t6_mid", d1(2), 2176);
    chk("t6_busy", busy1[2], 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_dac", dac1, 0);
    chk("t6_rst_on", on1, 0);
    chk("t6_rst_busy", busy1, 0);
    chk("t6_rst_cnt", cnt1, 0);
    chk("t6_rst_rd", rddata1, 0);
    chk("t6_rst_err", err1, 0);
    chk("t6_rst_ready", c1_ready, 1);
    chk("t6_rst_dac2", dac2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
